// File: rtl/avalon_mem_pkg.sv
// Shared definitions for the Avalon-MM RAM responder and its helpers.
//   avm_state_t : bus-side handshake states (IDLE, STALL, ACCEPT)
//   WORD_W      : data word width in bits
//   LANES       : number of byte lanes per word
package avalon_mem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL  = 2'd1,
    ACCEPT = 2'd2
  } avm_state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: each lane of the result comes from new_word_i
// when its enable bit is set, otherwise from old_word_i.
//   old_word_i [WORD_W-1:0] : current memory word
//   new_word_i [WORD_W-1:0] : incoming write data
//   lane_en_i  [LANES-1:0]  : lane enables, bit0 = bits[7:0]
//   merged_o   [WORD_W-1:0] : merged word
module byte_lane_merge
  import avalon_mem_pkg::*;
(
  input  logic [WORD_W-1:0] old_word_i,
  input  logic [WORD_W-1:0] new_word_i,
  input  logic [LANES-1:0]  lane_en_i,
  output logic [WORD_W-1:0] merged_o
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign merged_o[gi*8 +: 8] = lane_en_i[gi] ? new_word_i[gi*8 +: 8]
                                               : old_word_i[gi*8 +: 8];
  end

endmodule

// File: rtl/avalon_ram_responder.sv
// Avalon-MM slave RAM with a fixed number of waitrequest stall cycles per
// transfer, byte-lane writes and a synchronous preload port.
//   clk, reset (async, active-low)
//   address/read/write/writedata/byteenable : Avalon request from the master
//   waitrequest/readdata                    : Avalon response
//   load_en/load_addr/load_data             : preload port, independent of FSM
module avalon_ram_responder
  import avalon_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [WORD_W-1:0] writedata,
  input  logic [LANES-1:0]  byteenable,
  output logic              waitrequest,
  output logic [WORD_W-1:0] readdata,
  input  logic              load_en,
  input  logic [7:0]        load_addr,
  input  logic [WORD_W-1:0] load_data
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_C    = 4'(WAIT_CYCLES);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  avm_state_t        state_q;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic [WORD_W-1:0] readdata_q;

  logic              req;
  logic              enter_accept;
  logic [31:0]       offset;
  logic              in_window;
  logic [AW-1:0]     bus_idx;
  logic [AW-1:0]     load_idx;
  logic [WORD_W-1:0] merged;
  logic              commit;

  assign req         = read | write;
  assign waitrequest = req && (state_q != ACCEPT);
  assign readdata    = readdata_q;

  // Offset only meaningful when address >= BASE_ADDR; the window test guards
  // against the subtraction wrapping.
  assign offset    = address - BASE_ADDR;
  assign in_window = (address >= BASE_ADDR) && (offset < WIN_BYTES);
  assign bus_idx   = AW'(offset >> 2);
  assign load_idx  = AW'(load_addr >> 2);

  // Counter value the FSM would hold after this edge; reaching WAIT_C means
  // the next cycle is the completing (ACCEPT) cycle.
  assign cnt_d        = (state_q == IDLE) ? 4'd1 : cnt_q + 4'd1;
  assign enter_accept = req && (state_q != ACCEPT) && (cnt_d == WAIT_C);

  // Write commits on the edge leaving ACCEPT; a write with read also high is
  // still a write.
  assign commit = (state_q == ACCEPT) && write && in_window;

  byte_lane_merge u_merge (
    .old_word_i (mem[bus_idx]),
    .new_word_i (writedata),
    .lane_en_i  (byteenable),
    .merged_o   (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= '0;
    end else begin
      case (state_q)
        IDLE, STALL: begin
          if (!req) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q   <= cnt_d;
            state_q <= enter_accept ? ACCEPT : STALL;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
      if (enter_accept && read && !write) begin
        readdata_q <= (in_window && (byteenable != '0)) ? mem[bus_idx] : '0;
      end
    end
  end

  // RAM contents survive reset, so this block has no reset branch. The preload
  // is written last so it wins a same-word collision with a bus write.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[bus_idx] <= merged;
    end
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

endmodule

// File: doc/avalon_ram_responder.md
# avalon_ram_responder

Avalon memory-mapped slave (responder) that serves the CPU's bus master: a word-organised RAM answering `read`/`write` requests with a programmable number of `waitrequest` stall cycles and byte-lane writes. It also has a synchronous preload port through which benches place program words before the CPU runs. It sits on the far side of the CPU's Avalon master bus, in place of the behavioural test RAM.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, ≥4.
- `WAIT_CYCLES`, 1: stall cycles per transfer; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low (0 = in reset).
- `address` in 32: byte address; bits [1:0] ignored.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in 32: write data.
- `byteenable` in 4: lane enables; bit0 = bits[7:0] … bit3 = bits[31:24].
- `waitrequest` out 1: stall; the transfer completes on the edge where the request is high and this is low.
- `readdata` out 32: read data, valid in the completing cycle.
- `load_en` in 1: preload strobe.
- `load_addr` in 8: preload byte offset from `BASE_ADDR`; bits [1:0] ignored.
- `load_data` in 32: full word written on preload.

## Operation
- FSM states: IDLE, STALL, ACCEPT.
- IDLE: on `read|write` high, go to STALL and set the counter to 1.
- STALL: the counter increments each cycle. When counter == `WAIT_CYCLES`, go to ACCEPT. If `read|write` drops, go to IDLE with no side effects.
- ACCEPT: lasts one cycle. On its closing edge a write commits, then the FSM returns to IDLE. A request still high in the next cycle is a new transfer and starts from IDLE.
- `waitrequest` is combinational: `(read|write) && state != ACCEPT`. It is 0 whenever no request is present.
- Reads: `readdata` is registered and loaded on the edge entering ACCEPT. It holds until the next read. Reads outside the window or with all `byteenable` bits 0 return 32'h0. `byteenable` does not mask read data.
- Writes: only enabled lanes are updated. Writes outside the window are accepted (normal waitrequest timing) and discarded.
- Window: `BASE_ADDR <= address < BASE_ADDR + 4*DEPTH_WORDS`. Word index is `(address - BASE_ADDR) >> 2`.
- `read` and `write` both high: the transfer is treated as a write, and `readdata` is unchanged.
- `address`, `writedata` and `byteenable` are sampled on the edge entering ACCEPT (reads) or leaving ACCEPT (writes). The master must hold them stable while stalled.
- Preload: when `load_en` is high, the full word at `load_addr>>2` (modulo `DEPTH_WORDS`) is written at that edge. It is independent of the FSM.
- Preload and a committing bus write to the same word in the same cycle: the preload wins and the bus write is lost. Different words: both commit.

## Timing
- Reset values: state IDLE, counter 0, `readdata` 32'h0. `waitrequest` follows its input equation.
- RAM contents are not cleared by reset.
- Latency: a request first seen in cycle 0 has `waitrequest` high for cycles 0..`WAIT_CYCLES`-1 and low in cycle `WAIT_CYCLES`, when it completes. Throughput is one transfer per `WAIT_CYCLES`+1 cycles.
- Reset asserted mid-transfer: abort at once, no write commits, FSM restarts from IDLE after release. A request still held after release restarts with full stall.
- Preload is accepted during reset (for bench use).

## Structure
- Shared package `avalon_mem_pkg`: state enum `avm_state_t {IDLE, STALL, ACCEPT}`, word width 32, byte-lane count 4.
- The RAM array lives in this module.
- One natural sub-module, `byte_lane_merge`: combinational merge of old word, new data and `byteenable`. It is reused by future caches.

## Test plan
- Preload 0x2402FFFF at `load_addr` 0x04, then read 0x04 with `WAIT_CYCLES`=1 -> `waitrequest` high 1 cycle, then low with `readdata`=0x2402FFFF.
- Write 0xAABBCCDD with `byteenable`=4'b0101 to a word preloaded with 0x11223344, then read back -> 0x11BB33DD.
- `WAIT_CYCLES`=3, back-to-back reads of 0x08 and 0x0C -> each takes 4 cycles, and the second read's stall starts the cycle after the first completes.
- Read 0x100 (outside the 64-word window) -> 32'h0. Write 0x100 -> accepted, and no array word changes.
- Read dropped after 1 stall cycle with `WAIT_CYCLES`=3 -> FSM returns to IDLE. A following read completes in 4 cycles.
- Reset pulled low during the STALL of a write to 0x10 (value 0xDEADBEEF) -> word 0x10 keeps its preloaded 0x00000008, `readdata`=0, and after release the held write completes after a full stall.
